// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the calculator front-end sequencer
//
// Purpose : FSM state and mode encodings, ALU flag bit positions and the
//           default operand width shared by the sequencer files.
// Ports   : none (package).
package calc_pkg;

  localparam int CALC_WIDTH = 4;

  // Bit positions inside the 4-bit {N,Z,C,V} flag word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXEC,
    WAIT
  } state_e;

  typedef enum logic [1:0] {
    MODE_STEP    = 2'b00,
    MODE_REPEAT  = 2'b01,
    MODE_HOLD    = 2'b10,
    MODE_RESTART = 2'b11
  } mode_e;

endpackage

// File: rtl/btn_debouncer.sv
// rtl/btn_debouncer.sv - synchronizer and stable-level debouncer for an active-low push-button
//
// Purpose : brings the raw button into the clk domain, waits for DEB_CYCLES
//           consecutive cycles of a new level before accepting it, and pulses
//           press for one cycle on each accepted press (1->0). Release is silent.
// Ports   : clk, rst (async, active-high)
//           btn_n  raw button, active-low, asynchronous to clk
//           press  one-cycle pulse per debounced press
module btn_debouncer #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Synchronizer and debounced level reset to "released" (high)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      press <= 1'b0;
      // cnt tracks how many consecutive cycles sync2 has disagreed with level
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_op_sequencer.sv
// rtl/calc_op_sequencer.sv - button/mode driven operation sequencer for the calculator datapath
//
// Purpose : decodes debounced presses by mode, steps the operation index,
//           latches operands, runs one ALU operation through a start/done
//           handshake with timeout, and holds the result and flags for display.
// Option  : CALC_AUTO_STEP_EN - in STEP mode, a synthetic press every
//           AUTO_PERIOD cycles while idle.
// Ports   : clk, rst (async, active-high)
//           btn_change (raw KEY0, active-low), mode, Z, Y   user inputs
//           alu_a, alu_b, alu_op, alu_start                 ALU request
//           alu_done, alu_result, alu_flags                 ALU response
//           result_q, flags_q, result_valid                 held result
//           op_idx, busy, err                               status
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH       = CALC_WIDTH,
  parameter int N_OPS       = 10,
  parameter int DEB_CYCLES  = 500000,
  parameter int ALU_TIMEOUT = 15,
  parameter int AUTO_PERIOD = 50000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn_change,
  input  logic [1:0]               mode,
  input  logic [WIDTH-1:0]         Z,
  input  logic [WIDTH-1:0]         Y,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [$clog2(N_OPS)-1:0] alu_op,
  output logic                     alu_start,
  input  logic                     alu_done,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic [3:0]               alu_flags,
  output logic [WIDTH-1:0]         result_q,
  output logic [3:0]               flags_q,
  output logic [$clog2(N_OPS)-1:0] op_idx,
  output logic                     busy,
  output logic                     result_valid,
  output logic                     err
);

  localparam int OPW = $clog2(N_OPS);
  localparam int TW  = $clog2(ALU_TIMEOUT + 1);
  localparam logic [OPW-1:0] LAST_OP  = OPW'(N_OPS - 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(ALU_TIMEOUT - 1);

  state_e        state;
  state_e        next_state;
  mode_e         mode_sel;
  logic          press;
  logic          auto_ev;
  logic          ev;
  logic          accept;
  logic          capture;
  logic          timeout;
  logic [TW-1:0] wait_cnt;

  assign mode_sel = mode_e'(mode);

  btn_debouncer #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk  (clk),
    .rst  (rst),
    .btn_n(btn_change),
    .press(press)
  );

`ifdef CALC_AUTO_STEP_EN
  localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);

  logic [AW-1:0] auto_cnt;
  logic [1:0]    mode_q;

  // Free-running period counter; a real press or a mode change restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_cnt <= '0;
      mode_q   <= 2'b00;
    end else begin
      mode_q <= mode;
      if (press || (mode != mode_q) || (auto_cnt == AUTO_LAST)) begin
        auto_cnt <= '0;
      end else begin
        auto_cnt <= auto_cnt + 1'b1;
      end
    end
  end

  assign auto_ev = (auto_cnt == AUTO_LAST) && (state == IDLE) &&
                   (mode_sel == MODE_STEP) && (mode == mode_q);
`else
  // Synthetic events never occur in this build
  assign auto_ev = 1'b0 && (AUTO_PERIOD > 0);
`endif

  // A real press and a synthetic one in the same cycle collapse to one event
  assign ev = press | auto_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    alu_start  = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (ev && (mode_sel != MODE_HOLD)) begin
          accept     = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD: begin
        busy       = 1'b1;
        next_state = EXEC;
      end
      EXEC: begin
        busy      = 1'b1;
        alu_start = 1'b1;
        // done may arrive in the start cycle from a zero-latency ALU
        if (alu_done) begin
          capture    = 1'b1;
          next_state = IDLE;
        end else begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (alu_done) begin
          capture    = 1'b1;
          next_state = IDLE;
        end else if (wait_cnt == TMO_LAST) begin
          timeout    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_idx       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      result_q     <= '0;
      flags_q      <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      result_valid <= 1'b0;

      if (accept) begin
        case (mode_sel)
          MODE_STEP:    op_idx <= (op_idx == LAST_OP) ? '0 : op_idx + 1'b1;
          MODE_RESTART: begin
            op_idx <= '0;
            err    <= 1'b0;
          end
          default: ;
        endcase
      end

      // Operands are sampled only here and held until the next operation
      if (state == LOAD) begin
        alu_a  <= Z;
        alu_b  <= Y;
        alu_op <= op_idx;
      end

      if (state == EXEC) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (capture) begin
        result_q     <= alu_result;
        flags_q      <= alu_flags;
        result_valid <= 1'b1;
      end

      if (timeout) begin
        err          <= 1'b1;
        result_q     <= '0;
        flags_q      <= '0;
        result_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb/tb_calc_op_sequencer.sv - randomized model-checked bench for calc_op_sequencer
module tb_calc_op_sequencer;

  localparam int DEB   = 4;
  localparam int NOPS  = 10;
  localparam int TMO   = 15;
  localparam int NEVER = -1;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_change;
  logic [1:0] mode;
  logic [3:0] Z, Y;
  logic [3:0] alu_a, alu_b, alu_op;
  logic       alu_start;
  logic       alu_done;
  logic [3:0] alu_result;
  logic [3:0] alu_flags;
  logic [3:0] result_q, flags_q, op_idx;
  logic       busy, result_valid, err;

  calc_op_sequencer #(
    .WIDTH(4), .N_OPS(NOPS), .DEB_CYCLES(DEB), .ALU_TIMEOUT(TMO), .AUTO_PERIOD(50)
  ) dut (
    .clk(clk), .rst(rst), .btn_change(btn_change), .mode(mode), .Z(Z), .Y(Y),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags),
    .result_q(result_q), .flags_q(flags_q), .op_idx(op_idx), .busy(busy),
    .result_valid(result_valid), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // ALU stimulus
  int         alu_lat = 2;
  int         done_at = -1;
  logic [3:0] alu_res_hold, alu_flg_hold;
  bit         rand_zy = 0;

  // Watchers
  int start_cnt = 0, rv_cnt = 0, last_start_cyc = 0, last_rv_cyc = 0;

  // Reference model: time-stamped operation record plus button sample history
  bit         hist[$];
  bit         m_deb = 1, m_press = 0, m_in_op = 0;
  int         m_load_cyc = 0, m_start_cyc = 0;
  logic [3:0] m_op_idx = 0, m_a = 0, m_b = 0, m_op = 0, m_res = 0, m_flags = 0;
  bit         m_err = 0, m_rv = 0, m_start = 0, m_busy = 0;

  function automatic bit hist_at(int i);
    return (i < 0) ? 1'b1 : hist[i];
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Uses the inputs of cycle cyc to predict the outputs of cycle cyc+1
  task automatic model_advance();
    bit v, all_same, nxt_press;
    hist.push_back(rst ? 1'b1 : btn_change);
    if (rst) begin
      m_deb = 1; m_press = 0; m_in_op = 0;
      m_op_idx = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flags = 0;
      m_err = 0; m_rv = 0; m_start = 0; m_busy = 0;
      return;
    end
    m_rv = 0;
    m_start = 0;
    if (m_in_op) begin
      if (cyc == m_load_cyc) begin
        m_a = Z; m_b = Y; m_op = m_op_idx; m_start = 1;
      end else if (alu_done) begin
        m_res = alu_result; m_flags = alu_flags; m_rv = 1; m_in_op = 0;
      end else if (cyc == m_start_cyc + TMO) begin
        m_err = 1; m_res = 0; m_flags = 0; m_rv = 1; m_in_op = 0;
      end
    end else if (m_press && mode != 2'b10) begin
      if (mode == 2'b00) m_op_idx = 4'((int'(m_op_idx) + 1) % NOPS);
      if (mode == 2'b11) begin m_op_idx = 0; m_err = 0; end
      m_in_op = 1;
      m_load_cyc = cyc + 1;
      m_start_cyc = cyc + 2;
    end
    m_busy = m_in_op;
    // Press in cycle e needs DEB identical synchronized samples btn[e-3..e-2-DEB]
    v = hist_at(cyc - 2);
    all_same = 1;
    for (int j = 0; j < DEB; j++) if (hist_at(cyc - 2 - j) != v) all_same = 0;
    nxt_press = 0;
    if (all_same && v != m_deb) begin
      m_deb = v;
      nxt_press = !v;
    end
    m_press = nxt_press;
  endtask

  task automatic step();
    logic [27:0] act_v, exp_v;
    logic [4:0]  sum;
    model_advance();
    @(negedge clk);
    cyc++;
    act_v = {alu_a, alu_b, alu_op, alu_start, result_q, flags_q, op_idx, busy, result_valid, err};
    exp_v = {m_a, m_b, m_op, m_start, m_res, m_flags, m_op_idx, m_busy, m_rv, m_err};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL cycle %0d outputs: got %h expected %h", cyc, act_v, exp_v);
    end
    if (alu_start) begin start_cnt++; last_start_cyc = cyc; end
    if (result_valid) begin rv_cnt++; last_rv_cyc = cyc; end
    if (alu_start) begin
      if (alu_lat == NEVER) done_at = -1;
      else begin
        done_at = cyc + alu_lat;
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_res_hold = sum[3:0];
        alu_flg_hold = {sum[3], sum[3:0] == 4'd0, sum[4],
                        (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3])};
      end
    end
    alu_done = (cyc == done_at);
    alu_result = alu_done ? alu_res_hold : 4'($urandom);
    alu_flags  = alu_done ? alu_flg_hold : 4'($urandom);
    if (rand_zy) begin Z = 4'($urandom); Y = 4'($urandom); end
  endtask

  task automatic press_btn(int low, int high);
    btn_change = 1'b0;
    repeat (low) step();
    btn_change = 1'b1;
    repeat (high) step();
  endtask

  task automatic wait_rv(string name, int max);
    int n0 = rv_cnt;
    for (int i = 0; i < max && rv_cnt == n0; i++) step();
    chk({name, "_rv_seen"}, rv_cnt - n0, 1);
  endtask

  task automatic wait_start(string name, int max);
    int n0 = start_cnt;
    for (int i = 0; i < max && start_cnt == n0; i++) step();
    chk({name, "_start_seen"}, start_cnt - n0, 1);
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  initial begin
    int s0, r0, r;
    int exp_seq[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
    rst = 1'b1; btn_change = 1'b1; mode = 2'b00; Z = 0; Y = 0;
    alu_done = 0; alu_result = 0; alu_flags = 0;

    // Reset, with short glitches during and after reset
    step();
    chk("reset_outputs",
        int'({alu_a, alu_b, alu_op, alu_start, result_q, flags_q, op_idx, busy, result_valid, err}), 0);
    btn_change = 1'b0; step(); btn_change = 1'b1; step();
    rst = 1'b0;
    press_btn(1, 3); press_btn(2, 3); press_btn(3, 8);
    chk("glitch_no_start", start_cnt, 0);
    chk("glitch_op_idx", int'(op_idx), 0);
    chk("glitch_busy", int'(busy), 0);

    // STEP: one clean press
    mode = 2'b00; Z = 4'd1; Y = 4'd1; alu_lat = 2; s0 = start_cnt;
    press_btn(6, 0);
    wait_rv("step", 40);
    chk("step_starts", start_cnt - s0, 1);
    chk("step_op_idx", int'(op_idx), 1);
    chk("step_alu_op", int'(alu_op), 1);
    chk("step_alu_a", int'(alu_a), 1);
    chk("step_alu_b", int'(alu_b), 1);
    chk("step_result", int'(result_q), 2);
    chk("step_flags", int'(flags_q), 0);
    chk("step_start_to_rv", last_rv_cyc - last_start_cyc, 3);
    repeat (10) step();

    // Wrap: 10 presses from 0
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      press_btn(5, 4);
      wait_rv("wrap", 40);
      chk("wrap_op_idx", int'(op_idx), exp_seq[i]);
      repeat (6) step();
    end

    // HOLD then RESTART
    press_btn(5, 4); wait_rv("pre_hold", 40); repeat (6) step();
    mode = 2'b10; s0 = start_cnt;
    press_btn(6, 20);
    chk("hold_starts", start_cnt - s0, 0);
    chk("hold_op_idx", int'(op_idx), 1);
    mode = 2'b11; s0 = start_cnt;
    press_btn(6, 0);
    wait_rv("restart", 40);
    chk("restart_starts", start_cnt - s0, 1);
    chk("restart_op_idx", int'(op_idx), 0);
    repeat (10) step();

    // Busy drop and timeout
    mode = 2'b00; alu_lat = NEVER; s0 = start_cnt;
    btn_change = 1'b0; repeat (6) step(); btn_change = 1'b1;
    wait_start("tmo", 20);
    repeat (2) step();
    press_btn(5, 0);
    wait_rv("tmo", 40);
    chk("tmo_starts", start_cnt - s0, 1);
    chk("tmo_err", int'(err), 1);
    chk("tmo_result", int'(result_q), 0);
    chk("tmo_busy", int'(busy), 0);
    chk("tmo_op_idx", int'(op_idx), 1);
    chk("tmo_start_to_rv", last_rv_cyc - last_start_cyc, 16);
    repeat (10) step();

    // Reset mid-WAIT, late done must be ignored
    alu_lat = 10;
    press_btn(6, 0);
    wait_start("midrst", 20);
    repeat (3) step();
    do_reset(2);
    r0 = rv_cnt;
    repeat (15) step();
    chk("midrst_rv", rv_cnt - r0, 0);
    chk("midrst_result", int'(result_q), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_err", int'(err), 0);

    // Randomized traffic
    rand_zy = 1;
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 99));
      mode = (r < 40) ? 2'b00 : (r < 65) ? 2'b01 : (r < 80) ? 2'b10 : 2'b11;
      alu_lat = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, TMO));
      if ($urandom_range(0, 99) < 3) do_reset(2);
      if ($urandom_range(0, 4) == 0) press_btn(int'($urandom_range(1, 3)), int'($urandom_range(1, 10)));
      else press_btn(int'($urandom_range(DEB, DEB + 4)), int'($urandom_range(0, 25)));
    end
    rand_zy = 0;
    btn_change = 1'b1;
    repeat (30) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
